// File: rtl/pkt_queue_bank_pkg.sv
// Shared definitions for the packet queue bank and its downstream arbiter.
// Both blocks take their default NUM_REQS from here, so they always agree
// on how many requestor lanes exist.
package pkt_queue_bank_pkg;

  localparam int NUM_REQS_DEF = 4;  // requestor queues / arbiter lanes
  localparam int DWID_DEF     = 8;  // packet data width
  localparam int DEPTH_DEF    = 4;  // entries per queue (power of two, >= 2)

  typedef logic [DWID_DEF-1:0] pkt_data_t;

endpackage

// File: rtl/pkt_fifo.sv
// One requestor queue: a circular FIFO with storage, read/write pointers,
// occupancy count and full/empty flags. The caller qualifies push and pop;
// this block trusts them (push only when !full, pop only when !empty).
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset (clears pointers and count)
//   push       write push_data at the write pointer this cycle
//   push_data  packet to enqueue
//   pop        retire the head entry this cycle
//   head_data  entry at the read pointer (valid when !empty)
//   full       count == DEPTH
//   empty      count == 0
module pkt_fifo
  import pkt_queue_bank_pkg::*;
#(
  parameter int DWID  = DWID_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [DWID-1:0] push_data,
  input  logic            pop,
  output logic [DWID-1:0] head_data,
  output logic            full,
  output logic            empty
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam logic [PTRW-1:0] PTR_ONE  = PTRW'(1);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);

  logic [DWID-1:0] mem [DEPTH];
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic [CNTW-1:0] count;

  // DEPTH is a power of two, so pointer overflow is the DEPTH-1 -> 0 wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately not reset; a reset empties the queue through
  // the pointers and count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];
  assign full      = (count == CNT_FULL);
  assign empty     = (count == '0);

endmodule

// File: rtl/pkt_queue_bank.sv
// Bank of NUM_REQS independent packet queues feeding an external arbiter.
// Non-empty queues raise reqs; the arbiter answers with a one-hot gnt, and
// the granted queue's head is presented one cycle later on out_*. Any
// malformed grant (multi-hot, or pointing at an empty queue) pops nothing
// and latches err until reset.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   push_vld   per-queue enqueue request
//   push_data  per-queue packet, queue i on [(i+1)*DWID-1:i*DWID]
//   push_rdy   per-queue not-full (registered state only)
//   reqs       per-queue non-empty, to the arbiter
//   gnt        one-hot pop grant from the arbiter
//   out_vld    registered dequeue valid
//   out_data   dequeued packet (held when out_vld is low)
//   out_idx    source queue of out_data (held when out_vld is low)
//   err        sticky grant-protocol violation
module pkt_queue_bank
  import pkt_queue_bank_pkg::*;
#(
  parameter int NUM_REQS = NUM_REQS_DEF,
  parameter int DWID     = DWID_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int CNTWID   = $clog2(NUM_REQS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQS-1:0]      push_vld,
  input  logic [NUM_REQS*DWID-1:0] push_data,
  output logic [NUM_REQS-1:0]      push_rdy,
  output logic [NUM_REQS-1:0]      reqs,
  input  logic [NUM_REQS-1:0]      gnt,
  output logic                     out_vld,
  output logic [DWID-1:0]          out_data,
  output logic [CNTWID-1:0]        out_idx,
  output logic                     err
);

  logic [NUM_REQS-1:0] full;
  logic [NUM_REQS-1:0] empty;
  logic [NUM_REQS-1:0] push;
  logic [NUM_REQS-1:0] pop;
  logic [DWID-1:0]     head_data [NUM_REQS];

  logic                gnt_legal;
  logic                gnt_bad;
  logic [DWID-1:0]     sel_data;
  logic [CNTWID-1:0]   sel_idx;

  logic                out_vld_p1;
  logic [DWID-1:0]     out_data_p1;
  logic [CNTWID-1:0]   out_idx_p1;
  logic                err_p1;

  // A full queue refuses a push even if it is popped in the same cycle,
  // which keeps push_rdy free of any path from gnt.
  assign push_rdy = ~full;
  assign reqs     = ~empty;
  assign push     = push_vld & push_rdy;

  // Legal only if exactly one grant bit is set and it lands on a
  // non-empty queue; a zero gnt is simply an idle cycle.
  assign gnt_legal = $onehot(gnt) && ((gnt & reqs) != '0);
  assign gnt_bad   = (gnt != '0) && !gnt_legal;
  assign pop       = gnt_legal ? gnt : '0;

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_q
    pkt_fifo #(
      .DWID  (DWID),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[i]),
      .push_data (push_data[i*DWID +: DWID]),
      .pop       (pop[i]),
      .head_data (head_data[i]),
      .full      (full[i]),
      .empty     (empty[i])
    );
  end

  // Dequeue mux; its result is only captured when the grant is legal,
  // i.e. exactly one bit matches.
  always_comb begin
    sel_data = '0;
    sel_idx  = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (gnt[i]) begin
        sel_data = head_data[i];
        sel_idx  = CNTWID'(i);
      end
    end
  end

  // ---- stage p1: registered dequeue and sticky error ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_vld_p1  <= 1'b0;
      out_data_p1 <= '0;
      out_idx_p1  <= '0;
      err_p1      <= 1'b0;
    end else begin
      out_vld_p1 <= gnt_legal;
      if (gnt_legal) begin
        out_data_p1 <= sel_data;
        out_idx_p1  <= sel_idx;
      end
      if (gnt_bad) err_p1 <= 1'b1;
    end
  end

  assign out_vld  = out_vld_p1;
  assign out_data = out_data_p1;
  assign out_idx  = out_idx_p1;
  assign err      = err_p1;

endmodule

// File: tb/tb_pkt_queue_bank.sv
// Directed bench for pkt_queue_bank at default parameters (4 queues,
// 8-bit data, depth 4), followed by a constrained-random soak against a
// per-queue model.
module tb_pkt_queue_bank;

  logic        clk;
  logic        rst;
  logic [3:0]  push_vld;
  logic [31:0] push_data;
  logic [3:0]  push_rdy;
  logic [3:0]  reqs;
  logic [3:0]  gnt;
  logic        out_vld;
  logic [7:0]  out_data;
  logic [1:0]  out_idx;
  logic        err;

  int checks = 0;
  int errors = 0;

  pkt_queue_bank dut (
    .clk       (clk),
    .rst       (rst),
    .push_vld  (push_vld),
    .push_data (push_data),
    .push_rdy  (push_rdy),
    .reqs      (reqs),
    .gnt       (gnt),
    .out_vld   (out_vld),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs
  // sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int q, input logic [7:0] v);
    push_data[q*8 +: 8] = v;
  endtask

  logic [7:0] mq [4][$];
  logic [7:0] pend_data;
  logic [1:0] pend_idx;
  logic       pend_vld;
  logic [3:0] exp_reqs;
  int         exp_next;

  initial begin
    rst       = 1'b0;
    push_vld  = '0;
    push_data = '0;
    gnt       = '0;
    #12;

    // Reset state
    chk("rst_push_rdy", 32'(push_rdy), 32'hF);
    chk("rst_reqs",     32'(reqs),     32'h0);
    chk("rst_out_vld",  32'(out_vld),  32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_idx",  32'(out_idx),  32'h0);
    chk("rst_err",      32'(err),      32'h0);

    // Single push to queue 2 on the first edge after release, then pop
    tick();
    rst = 1'b1;
    push_vld = 4'b0100;
    set_lane(2, 8'hA1);
    tick();
    push_vld = '0;
    chk("q2_reqs", 32'(reqs), 32'h4);
    gnt = 4'b0100;
    tick();
    gnt = '0;
    chk("q2_out_vld",  32'(out_vld),  32'h1);
    chk("q2_out_data", 32'(out_data), 32'hA1);
    chk("q2_out_idx",  32'(out_idx),  32'h2);
    chk("q2_reqs_clr", 32'(reqs),     32'h0);
    tick();
    chk("idle_out_vld",  32'(out_vld),  32'h0);
    chk("idle_out_hold", 32'(out_data), 32'hA1);
    chk("idle_idx_hold", 32'(out_idx),  32'h2);

    // Fill queue 0, then push+pop on the full queue: push must be refused
    for (int k = 0; k < 4; k++) begin
      push_vld = 4'b0001;
      set_lane(0, 8'h10 + 8'(k));
      tick();
    end
    chk("q0_full_rdy", 32'(push_rdy), 32'hE);
    push_vld = 4'b0001;
    set_lane(0, 8'h99);
    gnt = 4'b0001;
    tick();
    push_vld = '0;
    chk("q0_pop_vld",  32'(out_vld),  32'h1);
    chk("q0_pop_data", 32'(out_data), 32'h10);
    chk("q0_rdy_back", 32'(push_rdy), 32'hF);
    for (int k = 1; k < 4; k++) begin
      gnt = 4'b0001;
      tick();
      chk("q0_drain", 32'(out_data), 32'h10 + 32'(k));
    end
    gnt = '0;
    chk("q0_refused", 32'(reqs), 32'h0);
    tick();

    // Queue 1: push 1..6 with a pop each cycle once non-empty; pointers wrap
    exp_next = 1;
    for (int k = 1; k <= 8; k++) begin
      push_vld = (k <= 6) ? 4'b0010 : 4'b0000;
      set_lane(1, 8'(k));
      gnt = reqs[1] ? 4'b0010 : 4'b0000;
      tick();
      if (out_vld) begin
        chk("q1_order", 32'(out_data), 32'(exp_next));
        chk("q1_idx",   32'(out_idx),  32'h1);
        exp_next++;
      end
    end
    push_vld = '0;
    gnt = '0;
    chk("q1_count", 32'(exp_next), 32'd7);
    chk("q1_empty", 32'(reqs), 32'h0);
    tick();

    // Illegal grants: multi-hot, then grant to an empty queue
    push_vld = 4'b1001;
    set_lane(0, 8'h30);
    set_lane(3, 8'h33);
    tick();
    push_vld = '0;
    chk("both_reqs", 32'(reqs), 32'h9);
    gnt = 4'b1001;
    tick();
    chk("multi_vld",  32'(out_vld), 32'h0);
    chk("multi_err",  32'(err),     32'h1);
    chk("multi_reqs", 32'(reqs),    32'h9);
    gnt = 4'b0010;
    tick();
    gnt = '0;
    chk("empty_vld",  32'(out_vld), 32'h0);
    chk("empty_reqs", 32'(reqs),    32'h9);
    chk("empty_hold", 32'(out_data), 32'h06);
    tick();
    tick();
    chk("err_sticky", 32'(err), 32'h1);
    gnt = 4'b0001;
    tick();
    chk("after_q0", 32'(out_data), 32'h30);
    gnt = 4'b1000;
    tick();
    gnt = '0;
    chk("after_q3",  32'(out_data), 32'h33);
    chk("after_idx", 32'(out_idx),  32'h3);
    chk("after_err", 32'(err),      32'h1);

    // Two packets in every queue, then reset mid-operation
    for (int k = 0; k < 2; k++) begin
      push_vld = 4'b1111;
      for (int q = 0; q < 4; q++) set_lane(q, 8'(8'h40 + q * 2 + k));
      tick();
    end
    push_vld = '0;
    chk("fill_reqs", 32'(reqs), 32'hF);
    rst = 1'b0;
    #1;
    chk("mrst_reqs", 32'(reqs),     32'h0);
    chk("mrst_rdy",  32'(push_rdy), 32'hF);
    chk("mrst_vld",  32'(out_vld),  32'h0);
    chk("mrst_err",  32'(err),      32'h0);
    tick();
    rst = 1'b1;
    push_vld = 4'b1000;
    set_lane(3, 8'h55);
    tick();
    push_vld = '0;
    gnt = 4'b1000;
    tick();
    gnt = '0;
    chk("post_data", 32'(out_data), 32'h55);
    chk("post_idx",  32'(out_idx),  32'h3);
    chk("post_vld",  32'(out_vld),  32'h1);
    chk("post_reqs", 32'(reqs),     32'h0);
    tick();

    // Random soak: legal one-hot grants on non-empty queues plus random pushes
    pend_vld = 1'b0;
    pend_data = '0;
    pend_idx = '0;
    for (int c = 0; c < 10000; c++) begin
      if (pend_vld) begin
        chk("rnd_vld",  32'(out_vld),  32'h1);
        chk("rnd_data", 32'(out_data), 32'(pend_data));
        chk("rnd_idx",  32'(out_idx),  32'(pend_idx));
      end else begin
        chk("rnd_idle", 32'(out_vld), 32'h0);
      end
      for (int q = 0; q < 4; q++) exp_reqs[q] = (mq[q].size() != 0);
      chk("rnd_reqs", 32'(reqs), 32'(exp_reqs));

      push_vld = 4'($urandom_range(0, 15));
      push_data = $urandom;
      gnt = '0;
      pend_vld = 1'b0;
      begin
        int g;
        g = $urandom_range(0, 3);
        if (mq[g].size() != 0 && $urandom_range(0, 3) != 0) begin
          gnt = 4'b0001 << g;
          pend_vld = 1'b1;
          pend_idx = 2'(g);
          pend_data = mq[g][0];
        end
      end
      // Accept test uses occupancy before this cycle's pop.
      for (int q = 0; q < 4; q++) begin
        if (push_vld[q] && mq[q].size() < 4) mq[q].push_back(push_data[q*8 +: 8]);
      end
      if (pend_vld) void'(mq[pend_idx].pop_front());
      tick();
    end
    push_vld = '0;
    gnt = '0;
    if (pend_vld) chk("rnd_last", 32'(out_data), 32'(pend_data));
    chk("rnd_err", 32'(err), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
